w_conv_ctrl: RTL

Iteration-loop controller for one FastICA component extraction. It sits directly downstream of `w_diff_norm` and consumes its `norm_out`/`output_valid` result. For each iteration it launches the weight update, triggers the ‖w − w_prev‖ computation, and compares the result against a threshold, including the sign-flipped case (norm ≈ 2). It then either starts the next iteration or terminates as converged, timed out or stalled.

---
 rtl/w_conv_ctrl.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/w_conv_ctrl.sv
// Iteration-loop controller for one FastICA component extraction: sequences
// update / diff-norm / threshold evaluation and reports convergence, timeout or stall.
module w_conv_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int FRAC_BITS  = 16,
    parameter int ITER_WIDTH = 8,
    parameter int MAX_ITER   = 100,
    parameter int CONSEC     = 2,
    parameter int FLIP_EN    = 1,
    parameter int WDOG_WIDTH = 10
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic                         abort,
    input  logic [DATA_WIDTH-1:0]        threshold,
    output logic                         iter_start,
    input  logic                         iter_done,
    output logic                         diff_en,
    input  logic                         norm_valid,
    input  logic signed [DATA_WIDTH-1:0] norm_in,
    output logic                         busy,
    output logic                         done,
    output logic                         converged,
    output logic                         timed_out,
    output logic                         stalled,
    output logic [ITER_WIDTH-1:0]        iter_count,
    output logic [DATA_WIDTH-1:0]        last_norm
);

    localparam int CW = (CONSEC < 1) ? 1 : $clog2(CONSEC + 1);
    localparam logic [CW-1:0]         CONSEC_V   = CW'(CONSEC);
    localparam logic [ITER_WIDTH-1:0] MAX_ITER_V = ITER_WIDTH'(MAX_ITER);
    localparam logic signed [DATA_WIDTH:0] TWO_V =
        $signed({{(DATA_WIDTH-FRAC_BITS-1){1'b0}}, 2'b10, {FRAC_BITS{1'b0}}});

    typedef enum logic [1:0] {IDLE, WAIT_ITER, WAIT_NORM, EVAL} state_t;

    state_t                  state, state_nxt;
    logic                    iter_start_nxt, diff_en_nxt, done_nxt, busy_nxt;
    logic                    conv_nxt, tout_nxt, stall_nxt;
    logic [ITER_WIDTH-1:0]   iter_nxt;
    logic [DATA_WIDTH-1:0]   last_nxt;
    logic [CW-1:0]           consec, consec_nxt, consec_new;
    logic [WDOG_WIDTH-1:0]   wdog, wdog_nxt;
    logic [DATA_WIDTH-1:0]   thr_q;
    logic                    accept;
    logic                    hit;

    // Norm at or below threshold, or (sign-flipped w) at or above TWO - threshold.
    function automatic logic is_hit(input logic signed [DATA_WIDTH-1:0] norm,
                                    input logic [DATA_WIDTH-1:0] thr);
        logic signed [DATA_WIDTH:0] n_ext;
        logic signed [DATA_WIDTH:0] t_ext;
        n_ext = $signed({norm[DATA_WIDTH-1], norm});
        t_ext = $signed({1'b0, thr});
        return (n_ext <= t_ext) || ((FLIP_EN != 0) && (n_ext >= (TWO_V - t_ext)));
    endfunction

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == CONSEC_V) ? v : v + 1'b1;
    endfunction

    assign hit        = is_hit($signed(last_norm), thr_q);
    assign consec_new = hit ? sat_inc(consec) : '0;

    always_comb begin
        state_nxt      = state;
        iter_start_nxt = 1'b0;
        diff_en_nxt    = 1'b0;
        done_nxt       = 1'b0;
        conv_nxt       = converged;
        tout_nxt       = timed_out;
        stall_nxt      = stalled;
        iter_nxt       = iter_count;
        last_nxt       = last_norm;
        consec_nxt     = consec;
        wdog_nxt       = wdog;
        accept         = 1'b0;
        if (abort) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        accept         = 1'b1;
                        iter_nxt       = '0;
                        consec_nxt     = '0;
                        last_nxt       = '0;
                        conv_nxt       = 1'b0;
                        tout_nxt       = 1'b0;
                        stall_nxt      = 1'b0;
                        iter_start_nxt = 1'b1;
                        state_nxt      = WAIT_ITER;
                    end
                end
                WAIT_ITER: begin
                    if (iter_done) begin
                        diff_en_nxt = 1'b1;
                        wdog_nxt    = '0;
                        state_nxt   = WAIT_NORM;
                    end
                end
                WAIT_NORM: begin
                    if (norm_valid) begin
                        last_nxt  = norm_in;
                        iter_nxt  = iter_count + 1'b1;
                        state_nxt = EVAL;
                    end else if (wdog == '1) begin
                        stall_nxt = 1'b1;
                        done_nxt  = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        wdog_nxt = wdog + 1'b1;
                    end
                end
                EVAL: begin
                    consec_nxt = consec_new;
                    // Convergence wins over timeout when both happen on the same evaluation.
                    if (consec_new == CONSEC_V) begin
                        conv_nxt  = 1'b1;
                        done_nxt  = 1'b1;
                        state_nxt = IDLE;
                    end else if (iter_count == MAX_ITER_V) begin
                        tout_nxt  = 1'b1;
                        done_nxt  = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        iter_start_nxt = 1'b1;
                        state_nxt      = WAIT_ITER;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
        busy_nxt = (state_nxt != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            busy       <= 1'b0;
            iter_start <= 1'b0;
            diff_en    <= 1'b0;
            done       <= 1'b0;
            converged  <= 1'b0;
            timed_out  <= 1'b0;
            stalled    <= 1'b0;
            iter_count <= '0;
            last_norm  <= '0;
            consec     <= '0;
            wdog       <= '0;
        end else begin
            state      <= state_nxt;
            busy       <= busy_nxt;
            iter_start <= iter_start_nxt;
            diff_en    <= diff_en_nxt;
            done       <= done_nxt;
            converged  <= conv_nxt;
            timed_out  <= tout_nxt;
            stalled    <= stall_nxt;
            iter_count <= iter_nxt;
            last_norm  <= last_nxt;
            consec     <= consec_nxt;
            wdog       <= wdog_nxt;
        end
    end

    // Threshold is a data word: only meaningful after an accepted start, so no reset.
    always_ff @(posedge clk) begin
        if (accept) thr_q <= threshold;
    end

endmodule
